// File: rtl/out_display.sv
// OUT-command display port: two 16-bit hex display registers scanned onto an
// 8-digit multiplexed 7-segment display, an LED register and a command counter.
module out_display #(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        out_valid,
    input  logic [2:0]  outsel,
    input  logic [15:0] outval1,
    input  logic [15:0] outval2,
    output logic [7:0]  seg,
    output logic [7:0]  dig,
    output logic [15:0] led,
    output logic [7:0]  out_count
);

    typedef enum logic [2:0] {
        CMD_LO   = 3'd0,
        CMD_HI   = 3'd1,
        CMD_BOTH = 3'd2,
        CMD_LED  = 3'd3,
        CMD_CLR  = 3'd4
    } cmd_e;

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] r_disp_lo;
    logic [15:0] r_disp_hi;
    logic [15:0] r_led;
    logic [7:0]  r_count;
    logic [15:0] r_presc;
    logic [2:0]  r_dig_idx;
    logic [7:0]  r_seg;
    logic [7:0]  r_dig;

    cmd_e        w_cmd;
    logic        w_counted;
    logic [31:0] w_digits;
    logic [3:0]  w_nibble;
    logic [7:0]  w_seg_next;
    logic [7:0]  w_dig_next;

    assign w_cmd     = cmd_e'(outsel);
    // Gate on out_valid first so an undriven selector never reaches the counter.
    assign w_counted = out_valid && (outsel <= 3'd4);
    assign w_digits  = {r_disp_hi, r_disp_lo};
    assign w_nibble  = w_digits[{r_dig_idx, 2'b00} +: 4];

    always_comb begin
        w_dig_next = '1;
        w_dig_next[r_dig_idx] = 1'b0;
    end

    always_comb begin
        w_seg_next = 8'hFF;
        case (w_nibble)
            4'h0: w_seg_next = 8'hC0;
            4'h1: w_seg_next = 8'hF9;
            4'h2: w_seg_next = 8'hA4;
            4'h3: w_seg_next = 8'hB0;
            4'h4: w_seg_next = 8'h99;
            4'h5: w_seg_next = 8'h92;
            4'h6: w_seg_next = 8'h82;
            4'h7: w_seg_next = 8'hF8;
            4'h8: w_seg_next = 8'h80;
            4'h9: w_seg_next = 8'h90;
            4'hA: w_seg_next = 8'h88;
            4'hB: w_seg_next = 8'h83;
            4'hC: w_seg_next = 8'hC6;
            4'hD: w_seg_next = 8'hA1;
            4'hE: w_seg_next = 8'h86;
            4'hF: w_seg_next = 8'h8E;
            default: w_seg_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp_lo <= '0;
            r_disp_hi <= '0;
            r_led     <= '0;
            r_count   <= '0;
        end else begin
            if (out_valid) begin
                case (w_cmd)
                    CMD_LO:   r_disp_lo <= outval1;
                    CMD_HI:   r_disp_hi <= outval1;
                    CMD_BOTH: begin
                        r_disp_lo <= outval1;
                        r_disp_hi <= outval2;
                    end
                    CMD_LED:  r_led <= outval1;
                    CMD_CLR:  begin
                        r_disp_lo <= '0;
                        r_disp_hi <= '0;
                        r_led     <= '0;
                    end
                    default: ;
                endcase
            end
            if (w_counted) r_count <= r_count + 8'd1;
        end
    end

    // Segment/digit outputs are registered from the current scan state,
    // so they lag the digit index and display registers by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_dig_idx <= '0;
            r_seg     <= '1;
            r_dig     <= '1;
        end else begin
            if (r_presc == PRESC_MAX) begin
                r_presc   <= '0;
                r_dig_idx <= r_dig_idx + 3'd1;
            end else begin
                r_presc <= r_presc + 16'd1;
            end
            r_seg <= w_seg_next;
            r_dig <= w_dig_next;
        end
    end

    assign seg       = r_seg;
    assign dig       = r_dig;
    assign led       = r_led;
    assign out_count = r_count;

endmodule

// File: tb/tb_out_display.sv
// Self-checking bench for out_display: directed scenarios plus random command
// traffic, checked every cycle against a scan-position / register model.
module tb_out_display;

    localparam int DIV = 4;

    logic        clock;
    logic        reset;
    logic        out_valid;
    logic [2:0]  outsel;
    logic [15:0] outval1;
    logic [15:0] outval2;
    logic [7:0]  seg;
    logic [7:0]  dig;
    logic [15:0] led;
    logic [7:0]  out_count;

    int tests;
    int fails;

    logic [15:0] m_lo;
    logic [15:0] m_hi;
    logic [15:0] m_led;
    int          m_cnt;
    int          n_edges;
    logic [7:0]  font [16];

    out_display #(.SCAN_DIV(DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .out_valid (out_valid),
        .outsel    (outsel),
        .outval1   (outval1),
        .outval2   (outval2),
        .seg       (seg),
        .dig       (dig),
        .led       (led),
        .out_count (out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_lo    = '0;
        m_hi    = '0;
        m_led   = '0;
        m_cnt   = 0;
        n_edges = 0;
    endtask

    // One clock: expected seg/dig come from the scan position and display
    // contents as they stood before this edge; led/count from after it.
    task automatic cycle();
        int          idx;
        logic [31:0] digits;
        logic [7:0]  e_seg;
        logic [7:0]  e_dig;
        @(posedge clock);
        idx    = (n_edges / DIV) % 8;
        digits = {m_hi, m_lo};
        e_seg  = font[(digits >> (idx * 4)) & 32'hF];
        e_dig  = 8'hFF ^ (8'h01 << idx);
        if (out_valid === 1'b1) begin
            case (outsel)
                3'd0: m_lo = outval1;
                3'd1: m_hi = outval1;
                3'd2: begin m_lo = outval1; m_hi = outval2; end
                3'd3: m_led = outval1;
                3'd4: begin m_lo = '0; m_hi = '0; m_led = '0; end
                default: ;
            endcase
            if (outsel <= 3'd4) m_cnt = (m_cnt + 1) % 256;
        end
        n_edges++;
        @(negedge clock);
        check("seg", {8'h00, seg}, {8'h00, e_seg});
        check("dig", {8'h00, dig}, {8'h00, e_dig});
        check("led", led, m_led);
        check("out_count", {8'h00, out_count}, 16'(m_cnt));
    endtask

    task automatic idle(input int cycles);
        out_valid = 1'b0;
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_seg"}, {8'h00, seg}, 16'h00FF);
        check({tag, "_dig"}, {8'h00, dig}, 16'h00FF);
        check({tag, "_led"}, led, 16'h0000);
        check({tag, "_cnt"}, {8'h00, out_count}, 16'h0000);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        out_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("rst");
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        tests = 0;
        fails = 0;
        model_clear();
        reset = 1'b1;
        out_valid = 1'b0;
        outsel = '0;
        outval1 = '0;
        outval2 = '0;

        do_reset();

        // Idle scan: digit steps through all eight positions and wraps.
        idle(1);
        check("first_dig", {8'h00, dig}, 16'h00FE);
        check("first_seg", {8'h00, seg}, 16'h00C0);
        idle(36);

        // Load both display registers.
        out_valid = 1'b1; outsel = 3'd2; outval1 = 16'h1234; outval2 = 16'hABCD;
        cycle();
        idle(36);
        check("cnt_after_both", {8'h00, out_count}, 16'h0001);

        // LED load then clear on the following cycle.
        out_valid = 1'b1; outsel = 3'd3; outval1 = 16'h00FF;
        cycle();
        check("led_loaded", led, 16'h00FF);
        outsel = 3'd4;
        cycle();
        check("led_cleared", led, 16'h0000);
        idle(34);
        check("cnt_after_clr", {8'h00, out_count}, 16'h0003);

        // 256 back-to-back accepted commands wrap the counter; outsel 6 ignored.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            out_valid = 1'b1; outsel = 3'd0; outval1 = 16'($urandom);
            cycle();
        end
        outsel = 3'd6; outval1 = 16'hFFFF;
        cycle();
        check("cnt_wrap", {8'h00, out_count}, 16'h0000);
        idle(34);

        // Undriven selector/operands while out_valid is low.
        out_valid = 1'b0; outsel = 'x; outval1 = 'x; outval2 = 'x;
        for (int i = 0; i < 100; i++) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            out_valid = ($urandom_range(0, 2) != 0);
            outsel    = 3'($urandom_range(0, 7));
            outval1   = 16'($urandom);
            outval2   = 16'($urandom);
            cycle();
        end
        idle(34);

        // Reset asserted asynchronously while digit 5 is being scanned.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            out_valid = 1'b1; outsel = 3'($urandom_range(0, 4)); outval1 = 16'($urandom);
            outval2 = 16'($urandom);
            cycle();
        end
        check("pre_rst_dig5", {8'h00, dig}, 16'h00DF);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clock);
        check_reset_values("async_rst_hold");
        reset = 1'b0;
        out_valid = 1'b0;
        model_clear();
        idle(1);
        check("restart_dig", {8'h00, dig}, 16'h00FE);
        idle(35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
